// File: rtl/hdu_stall_ctrl_if.sv
// hdu_stall_ctrl_if: bundle between the ID/EX/MEM pipeline controls and the hazard unit.
//   master: the pipeline side. It drives ID sources, EX/MEM producer info and branch resolution,
//           and receives the stall/flush controls and the debug counters.
//   slave : the hazard/stall controller, which is the mirror image of master.
interface hdu_stall_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_regwriteen;
    logic             ex_memtoreg;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwriteen;
    logic             ex_branch_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             hazard;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rd, ex_regwriteen, ex_memtoreg, mem_rd, mem_regwriteen, ex_branch_taken,
        input  pc_we, ifid_we, ifid_flush, idex_flush, hazard, stall_cycles, stall_timeout
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rd, ex_regwriteen, ex_memtoreg, mem_rd, mem_regwriteen, ex_branch_taken,
        output pc_we, ifid_we, ifid_flush, idex_flush, hazard, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/hdu_stall_ctrl.sv
// hdu_stall_ctrl: RAW hazard detection and stall/flush control for the 5-stage MIPS pipeline.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : hdu_stall_ctrl_if.slave carrying the following signals.
//     in  : id_valid, id_rs/rt, id_use_rs/rt, ex_rd, ex_regwriteen, ex_memtoreg, mem_rd,
//           mem_regwriteen, ex_branch_taken
//     out : pc_we, ifid_we, ifid_flush, idex_flush, hazard (combinational),
//           stall_cycles (saturating), stall_timeout (sticky), both registered
module hdu_stall_ctrl #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned LOAD_LAT  = 1,
    parameter bit          FWD_EN    = 1'b1,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STALL = 8
) (
    input logic             clk,
    input logic             reset,
    hdu_stall_ctrl_if.slave bus
);
    // The tracker holds loads that have left EX but whose data are not yet forwardable.
    // It is kept at size 1 (tied off) when LOAD_LAT=1 so the declarations stay legal.
    localparam int          TRK_N  = (LOAD_LAT > 1) ? int'(LOAD_LAT) - 1 : 1;
    localparam int unsigned CONS_W = $clog2(MAX_STALL + 1);

    logic [TRK_N-1:0]            trk_vld_q;
    logic [TRK_N-1:0][REG_W-1:0] trk_rd_q;

    logic             rs_live, rt_live;
    logic             ex_hit, mem_hit, trk_hit;
    logic             raw_hazard;
    logic             hazard;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CONS_W-1:0] consec_q, consec_d, consec_inc;
    logic             timeout_q, timeout_d;

    // A source is "live" only if ID holds a real instruction that reads it and it is not r0.
    assign rs_live = bus.id_valid && bus.id_use_rs && (bus.id_rs != '0);
    assign rt_live = bus.id_valid && bus.id_use_rt && (bus.id_rt != '0);

    assign ex_hit  = (rs_live && (bus.id_rs == bus.ex_rd)) || (rt_live && (bus.id_rt == bus.ex_rd));
    assign mem_hit = (rs_live && (bus.id_rs == bus.mem_rd)) ||
                     (rt_live && (bus.id_rt == bus.mem_rd));

    always_comb begin
        trk_hit = 1'b0;
        for (int i = 0; i < TRK_N; i++) begin
            if (trk_vld_q[i] &&
                ((rs_live && (bus.id_rs == trk_rd_q[i])) ||
                 (rt_live && (bus.id_rt == trk_rd_q[i])))) begin
                trk_hit = 1'b1;
            end
        end
    end

    always_comb begin
        raw_hazard = (bus.ex_regwriteen && bus.ex_memtoreg && ex_hit) || trk_hit;
        // Without EX/MEM forwarding every in-flight writer must drain to WB first.
        if (!FWD_EN) begin
            raw_hazard = raw_hazard || (bus.ex_regwriteen && ex_hit) ||
                         (bus.mem_regwriteen && mem_hit);
        end
    end

    if (LOAD_LAT > 1) begin : g_trk
        // Shifts every cycle, stalls and flushes included: a load already past EX keeps moving
        // even when the front of the pipe is squashed.
        always_ff @(posedge clk) begin
            if (reset) begin
                trk_vld_q <= '0;
                trk_rd_q  <= '0;
            end else begin
                trk_vld_q[0] <= bus.ex_regwriteen && bus.ex_memtoreg && (bus.ex_rd != '0);
                trk_rd_q[0]  <= bus.ex_rd;
                for (int i = 1; i < TRK_N; i++) begin
                    trk_vld_q[i] <= trk_vld_q[i-1];
                    trk_rd_q[i]  <= trk_rd_q[i-1];
                end
            end
        end
    end else begin : g_no_trk
        assign trk_vld_q = '0;
        assign trk_rd_q  = '0;
    end

    // Priority: reset, then taken branch (squashes ID, so its hazard is moot), then stall.
    always_comb begin
        hazard         = 1'b0;
        bus.pc_we      = 1'b1;
        bus.ifid_we    = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        if (reset) begin
            bus.pc_we      = 1'b0;
            bus.ifid_we    = 1'b0;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else if (raw_hazard) begin
            hazard         = 1'b1;
            bus.pc_we      = 1'b0;
            bus.ifid_we    = 1'b0;
            bus.idex_flush = 1'b1;
        end
    end

    assign bus.hazard = hazard;

    // Debug counters.
    always_comb begin
        cnt_d      = cnt_q;
        consec_d   = '0;
        timeout_d  = timeout_q;
        consec_inc = (consec_q == CONS_W'(MAX_STALL)) ? consec_q : consec_q + 1'b1;
        if (hazard) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            consec_d = consec_inc;
            if (consec_inc == CONS_W'(MAX_STALL)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            consec_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            consec_q  <= consec_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.stall_cycles  = cnt_q;
    assign bus.stall_timeout = timeout_q;
endmodule
